branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/bp_pkg.sv | 35 +++
 rtl/sat_counter.sv | 34 +++
 rtl/branch_predictor.sv | 136 +++++++++++++
 tb/tb_branch_predictor.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared branch-predictor constants: default widths, PC alignment,
// counter encodings and the entry field layout.
// No ports (package).
package bp_pkg;

    localparam int unsigned BP_ADDR_W  = 8;
    localparam int unsigned BP_ENTRIES = 16;
    localparam int unsigned BP_CTR_W   = 2;
    localparam int unsigned BP_STAT_W  = 16;

    // Instructions are word aligned: the low PC bits carry no information.
    localparam int unsigned PC_ALIGN_LSB = 2;

    localparam int unsigned BP_IDX_W = $clog2(BP_ENTRIES);
    localparam int unsigned BP_TAG_W = BP_ADDR_W - BP_IDX_W - PC_ALIGN_LSB;

    // Entry field layout (shown at the default widths).
    typedef struct packed {
        logic                  valid;
        logic [BP_TAG_W-1:0]   tag;
        logic [BP_CTR_W-1:0]   ctr;
        logic [BP_ADDR_W-1:0]  target;
    } bp_entry_t;

    // Weakly-taken: MSB set, all other bits clear.
    function automatic int unsigned weak_taken(input int unsigned ctr_w);
        return 32'(1) << (ctr_w - 1);
    endfunction

    // Weakly-not-taken: MSB clear, all other bits set.
    function automatic int unsigned weak_not_taken(input int unsigned ctr_w);
        return (32'(1) << (ctr_w - 1)) - 32'(1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter holding one entry's taken confidence.
// Ports: clk, rst_n (sync, active low), i_load/i_load_val (overwrite),
//        i_inc/i_dec (saturating step), o_taken (counter MSB).
module sat_counter #(
    parameter int unsigned      CTR_W   = 2,
    parameter logic [CTR_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CTR_W-1:0] i_load_val,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic             o_taken
);

    logic [CTR_W-1:0] r_cnt;

    // Load has priority; inc/dec stop at the rails.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= RST_VAL;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_inc) begin
            if (r_cnt != '1) r_cnt <= r_cnt + CTR_W'(1);
        end else if (i_dec) begin
            if (r_cnt != '0) r_cnt <= r_cnt - CTR_W'(1);
        end
    end

    assign o_taken = r_cnt[CTR_W-1];

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating counters.
// Ports: clk, rst_n (sync, active low);
//        lookup  lkp_pc -> pred_hit / pred_taken / pred_target (combinational);
//        update  upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken;
//        clear   invalidates all entries;
//        stats   mispredict (registered pulse), mispredict_cnt (saturating).
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned ADDR_W  = BP_ADDR_W,
    parameter int unsigned ENTRIES = BP_ENTRIES,
    parameter int unsigned CTR_W   = BP_CTR_W,
    parameter int unsigned STAT_W  = BP_STAT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] lkp_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic              clear,
    output logic              mispredict,
    output logic [STAT_W-1:0] mispredict_cnt
);

    localparam int unsigned IDX_W   = $clog2(ENTRIES);
    localparam int unsigned TAG_LSB = IDX_W + PC_ALIGN_LSB;
    localparam int unsigned TAG_W   = (ADDR_W > TAG_LSB) ? ADDR_W - TAG_LSB : 0;
    // An empty tag is stored as a constant zero bit so every valid entry hits.
    localparam int unsigned TAG_S   = (TAG_W > 0) ? TAG_W : 1;

    localparam logic [CTR_W-1:0] CTR_RST   = CTR_W'(weak_not_taken(CTR_W));
    localparam logic [CTR_W-1:0] CTR_ALLOC = CTR_W'(weak_taken(CTR_W));

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_S-1:0]   r_tag    [ENTRIES];
    logic [ADDR_W-1:0]  r_target [ENTRIES];
    logic [ENTRIES-1:0] w_ctr_msb;
    logic               r_mispredict;
    logic [STAT_W-1:0]  r_mp_cnt;

    logic [IDX_W-1:0] w_lkp_idx, w_upd_idx;
    logic [TAG_S-1:0] w_lkp_tag, w_upd_tag;
    logic             w_lkp_hit, w_upd_hit;
    logic             w_mispred, w_write, w_alloc;
    logic             w_unused_pc_lsb;

    // Shifting past the top yields zero, which covers the empty-tag case.
    assign w_lkp_idx = IDX_W'(lkp_pc >> PC_ALIGN_LSB);
    assign w_upd_idx = IDX_W'(upd_pc >> PC_ALIGN_LSB);
    assign w_lkp_tag = TAG_S'(lkp_pc >> TAG_LSB);
    assign w_upd_tag = TAG_S'(upd_pc >> TAG_LSB);

    assign w_unused_pc_lsb = ^{lkp_pc[PC_ALIGN_LSB-1:0], upd_pc[PC_ALIGN_LSB-1:0]};

    assign w_lkp_hit = r_valid[w_lkp_idx] && (r_tag[w_lkp_idx] == w_lkp_tag);
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

    // Zero-latency lookup against the pre-update table.
    always_comb begin
        pred_hit    = w_lkp_hit;
        pred_taken  = 1'b0;
        pred_target = '0;
        if (w_lkp_hit) begin
            pred_taken  = w_ctr_msb[w_lkp_idx];
            pred_target = r_target[w_lkp_idx];
        end
    end

    // Direction wrong, or taken/taken with a stale stored target.
    assign w_mispred = upd_valid &&
                       ((upd_pred_taken != upd_taken) ||
                        (upd_taken && upd_pred_taken && w_upd_hit &&
                         (r_target[w_upd_idx] != upd_target)));

    // clear suppresses every table write in its cycle.
    assign w_write = upd_valid && !clear;
    assign w_alloc = w_write && upd_taken && !w_upd_hit;

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_ctr
        logic w_sel;
        assign w_sel = (w_upd_idx == IDX_W'(gi));

        sat_counter #(
            .CTR_W   (CTR_W),
            .RST_VAL (CTR_RST)
        ) u_ctr (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_load     (w_alloc && w_sel),
            .i_load_val (CTR_ALLOC),
            .i_inc      (w_write && w_upd_hit && upd_taken && w_sel),
            .i_dec      (w_write && w_upd_hit && !upd_taken && w_sel),
            .o_taken    (w_ctr_msb[gi])
        );
    end

    // Valid/tag/target table; taken updates always refresh the target.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
            end
        end else if (clear) begin
            r_valid <= '0;
        end else if (w_write && upd_taken) begin
            r_target[w_upd_idx] <= upd_target;
            if (!w_upd_hit) begin
                r_valid[w_upd_idx] <= 1'b1;
                r_tag[w_upd_idx]   <= w_upd_tag;
            end
        end
    end

    // Mispredict pulse and saturating statistics counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mispredict <= 1'b0;
            r_mp_cnt     <= '0;
        end else begin
            r_mispredict <= w_mispred;
            if (w_mispred && (r_mp_cnt != '1)) r_mp_cnt <= r_mp_cnt + STAT_W'(1);
        end
    end

    assign mispredict     = r_mispredict;
    assign mispredict_cnt = r_mp_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios with literal
// expectations, then randomized traffic against a behavioural table model.
// A second instance with STAT_W=2 shares all inputs to exercise saturation.
module tb_branch_predictor;

    logic       clk;
    logic       rst_n;
    logic [7:0] lkp_pc;
    logic       upd_valid, upd_taken, upd_pred_taken, clear;
    logic [7:0] upd_pc, upd_target;

    logic        pred_hit, pred_taken, mispredict;
    logic [7:0]  pred_target;
    logic [15:0] mispredict_cnt;

    logic        s_pred_hit, s_pred_taken, s_mispredict;
    logic [7:0]  s_pred_target;
    logic [1:0]  s_mispredict_cnt;

    int n_checks = 0;
    int n_errors = 0;

    branch_predictor dut (
        .clk(clk), .rst_n(rst_n), .lkp_pc(lkp_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .clear(clear),
        .mispredict(mispredict), .mispredict_cnt(mispredict_cnt)
    );

    branch_predictor #(.STAT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .lkp_pc(lkp_pc),
        .pred_hit(s_pred_hit), .pred_taken(s_pred_taken), .pred_target(s_pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .clear(clear),
        .mispredict(s_mispredict), .mispredict_cnt(s_mispredict_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a 16-slot table keyed by word index, tag = pc/64.
    bit m_on = 0;
    bit m_valid [16];
    int m_tag   [16];
    int m_ctr   [16];
    int m_tgt   [16];
    bit m_mp;
    int m_cnt;

    function automatic int idx_of(input int pc); return (pc / 4) % 16; endfunction
    function automatic int tag_of(input int pc); return pc / 64; endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_on = 1;
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 0; m_tag[i] = 0; m_ctr[i] = 1; m_tgt[i] = 0;
            end
            m_mp = 0; m_cnt = 0;
        end else begin
            int  ix;
            bit  hit;
            ix  = idx_of(int'(upd_pc));
            hit = m_valid[ix] && (m_tag[ix] == tag_of(int'(upd_pc)));
            m_mp = upd_valid && ((upd_pred_taken != upd_taken) ||
                   (upd_taken && upd_pred_taken && hit && m_tgt[ix] != int'(upd_target)));
            if (m_mp) m_cnt++;
            if (clear) begin
                for (int i = 0; i < 16; i++) m_valid[i] = 0;
            end else if (upd_valid) begin
                if (hit && upd_taken) begin
                    m_ctr[ix] = (m_ctr[ix] < 3) ? m_ctr[ix] + 1 : 3;
                    m_tgt[ix] = int'(upd_target);
                end else if (hit) begin
                    m_ctr[ix] = (m_ctr[ix] > 0) ? m_ctr[ix] - 1 : 0;
                end else if (upd_taken) begin
                    m_valid[ix] = 1; m_tag[ix] = tag_of(int'(upd_pc));
                    m_ctr[ix] = 2;   m_tgt[ix] = int'(upd_target);
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (m_on) begin
            int ix;
            bit eh, et;
            int etg;
            ix  = idx_of(int'(lkp_pc));
            eh  = m_valid[ix] && (m_tag[ix] == tag_of(int'(lkp_pc)));
            et  = eh && (m_ctr[ix] >= 2);
            etg = eh ? m_tgt[ix] : 0;
            chk("pred_hit",    32'(pred_hit),    32'(eh));
            chk("pred_taken",  32'(pred_taken),  32'(et));
            chk("pred_target", 32'(pred_target), 32'(etg));
            chk("mispredict",  32'(mispredict),  32'(m_mp));
            chk("mp_cnt",      32'(mispredict_cnt), 32'((m_cnt > 65535) ? 65535 : m_cnt));
            chk("s_pred_hit",  32'(s_pred_hit),  32'(eh));
            chk("s_mispredict",32'(s_mispredict),32'(m_mp));
            chk("s_mp_cnt",    32'(s_mispredict_cnt), 32'((m_cnt > 3) ? 3 : m_cnt));
        end
    end

    task automatic drive(input logic [7:0] lpc, input logic uv, input logic [7:0] upc,
                         input logic ut, input logic [7:0] utg, input logic upt,
                         input logic clr);
        lkp_pc = lpc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
        upd_target = utg; upd_pred_taken = upt; clear = clr;
    endtask

    task automatic idle(input logic [7:0] lpc);
        drive(lpc, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic at_check; @(negedge clk); #1; endtask
    task automatic next_cyc; @(posedge clk); #1; endtask

    initial begin
        rst_n = 1'b0;
        // Reset must override a simultaneous update and clear.
        drive(8'h10, 1'b1, 8'h10, 1'b1, 8'h40, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(8'h10);
        at_check;
        chk("rst_hit", 32'(pred_hit), 0);
        chk("rst_taken", 32'(pred_taken), 0);
        chk("rst_target", 32'(pred_target), 0);
        chk("rst_cnt", 32'(mispredict_cnt), 0);
        next_cyc;

        // Allocate 0x10 -> 0x40 with a not-taken prediction.
        drive(8'h10, 1'b1, 8'h10, 1'b1, 8'h40, 1'b0, 1'b0);
        at_check;
        chk("alloc_same_cycle_hit", 32'(pred_hit), 0);
        next_cyc;
        idle(8'h10);
        at_check;
        chk("alloc_hit", 32'(pred_hit), 1);
        chk("alloc_taken", 32'(pred_taken), 1);
        chk("alloc_target", 32'(pred_target), 32'h40);
        chk("alloc_mp_pulse", 32'(mispredict), 1);
        chk("alloc_cnt", 32'(mispredict_cnt), 1);
        next_cyc;
        at_check;
        chk("mp_pulse_end", 32'(mispredict), 0);
        next_cyc;

        // Three not-taken updates: counter 2 -> 1 -> 0 -> 0.
        for (int k = 0; k < 3; k++) begin
            drive(8'h10, 1'b1, 8'h10, 1'b0, 8'h99, 1'b0, 1'b0);
            next_cyc;
        end
        idle(8'h10);
        at_check;
        chk("dec_hit", 32'(pred_hit), 1);
        chk("dec_taken", 32'(pred_taken), 0);
        chk("dec_target_kept", 32'(pred_target), 32'h40);
        chk("dec_cnt", 32'(mispredict_cnt), 1);
        next_cyc;

        // Conflicting tag at the same index replaces the occupant.
        drive(8'h10, 1'b1, 8'h50, 1'b1, 8'h88, 1'b0, 1'b0);
        next_cyc;
        idle(8'h10);
        at_check;
        chk("evict_old_miss", 32'(pred_hit), 0);
        chk("evict_cnt", 32'(mispredict_cnt), 2);
        next_cyc;
        idle(8'h50);
        at_check;
        chk("evict_new_hit", 32'(pred_hit), 1);
        chk("evict_new_target", 32'(pred_target), 32'h88);
        next_cyc;

        // Same-cycle allocate and lookup of 0x20.
        drive(8'h20, 1'b1, 8'h20, 1'b1, 8'h33, 1'b1, 1'b0);
        at_check;
        chk("bypass_miss", 32'(pred_hit), 0);
        next_cyc;
        idle(8'h20);
        at_check;
        chk("bypass_next_hit", 32'(pred_hit), 1);
        chk("bypass_target", 32'(pred_target), 32'h33);
        chk("bypass_no_mp", 32'(mispredict), 0);
        next_cyc;

        // Correct direction but wrong stored target is a mispredict.
        drive(8'h20, 1'b1, 8'h20, 1'b1, 8'h44, 1'b1, 1'b0);
        next_cyc;
        idle(8'h20);
        at_check;
        chk("tgt_mp_pulse", 32'(mispredict), 1);
        chk("tgt_mp_cnt", 32'(mispredict_cnt), 3);
        chk("tgt_new_target", 32'(pred_target), 32'h44);
        next_cyc;

        // clear beats a simultaneous mispredicted allocate.
        drive(8'h20, 1'b1, 8'h60, 1'b1, 8'h11, 1'b0, 1'b1);
        next_cyc;
        idle(8'h20);
        at_check;
        chk("clear_miss_20", 32'(pred_hit), 0);
        chk("clear_cnt", 32'(mispredict_cnt), 4);
        next_cyc;
        idle(8'h50);
        at_check;
        chk("clear_miss_50", 32'(pred_hit), 0);
        next_cyc;
        idle(8'h60);
        at_check;
        chk("clear_no_alloc_60", 32'(pred_hit), 0);
        next_cyc;

        // Two more mispredicts: narrow counter holds at 3.
        for (int k = 0; k < 2; k++) begin
            drive(8'h70, 1'b1, 8'h70, 1'b0, 8'h00, 1'b1, 1'b0);
            next_cyc;
        end
        idle(8'h70);
        at_check;
        chk("wide_cnt", 32'(mispredict_cnt), 6);
        chk("narrow_cnt_sat", 32'(s_mispredict_cnt), 3);
        next_cyc;

        // Randomized traffic over a small address pool to provoke hits.
        for (int c = 0; c < 3000; c++) begin
            logic [7:0] lpc, upc, utg;
            lpc = 8'(($urandom_range(0, 1) << 6) | ($urandom_range(0, 15) << 2));
            upc = 8'(($urandom_range(0, 1) << 6) | ($urandom_range(0, 15) << 2));
            if ($urandom_range(0, 9) == 0) lpc = 8'($urandom);
            if ($urandom_range(0, 9) == 0) upc = 8'($urandom);
            utg = 8'($urandom_range(0, 3) * 16);
            rst_n = ($urandom_range(0, 499) != 0);
            drive(lpc, 1'($urandom_range(0, 9) < 6), upc, 1'($urandom_range(0, 1)),
                  utg, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0));
            next_cyc;
        end
        rst_n = 1'b1;
        idle(8'h00);
        at_check;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
